muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle HI/LO arithmetic unit that sits beside the execute-stage ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and handles MTHI/MTLO writes.
- Holds the architectural HI/LO registers.
- The execute stage stalls on req_ready=0. MFHI/MFLO read the hi/lo outputs directly.
- Generalises the single-cycle ALU path: parametrised width, multi-cycle operation, flush-abort.

Parameters:
- WIDTH, 32: operand, HI and LO width; must be ≥4.
- CNT_W, $clog2(WIDTH): iteration counter width (derived, not overridden).

Ports:
- clk  in  1: clock.
- reset  in  1: synchronous, active-high reset.
- req_valid  in  1: request present.
- req_ready  out  1: unit can accept a request; equals (state==IDLE) & ~reset.
- req_op  in  3: operation code. 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 accepted as no-op.
- req_a  in  WIDTH: rs operand (multiplicand/dividend; MTHI/MTLO data).
- req_b  in  WIDTH: rt operand (multiplier/divisor).
- flush  in  1: abort any in-flight operation and block acceptance this cycle.
- busy  out  1: state != IDLE.
- done  out  1: one-cycle pulse; hi/lo hold a new MULT/DIV result this cycle.
- hi  out  WIDTH: HI register.
- lo  out  WIDTH: LO register.

Behaviour:
- Accept condition: req_valid & req_ready & ~flush, sampled at the rising edge.
- Reset: state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0. Reset overrides flush and requests, including mid-operation.
- States are IDLE, CALC and FIX.
- IDLE, on accepting MULT*/DIV*:
  - Latch |a|, |b| (signed ops) or a, b (unsigned ops), the op, and the sign flags.
  - Counter = WIDTH-1; go to CALC.
- IDLE, on accepting MTHI/MTLO: write hi/lo at that edge, stay in IDLE, no done pulse. Codes 110/111 change nothing.
- CALC:
  - Multiply: shift-add on a 2*WIDTH product, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - Counter decrements each cycle; at counter==0, go to FIX.
- FIX (1 cycle):
  - Apply sign correction. Product negated if sign(a)^sign(b). Quotient negated if sign(a)^sign(b). Remainder takes the sign of the dividend.
  - Write hi/lo at the exit edge; go to IDLE with done=1 for exactly one cycle.
- Latency: request accepted at edge of cycle 0. CALC occupies cycles 1..WIDTH, FIX occupies cycle WIDTH+1. New hi/lo and done=1 appear in cycle WIDTH+2, where req_ready=1 and a back-to-back request is accepted.
- Multiply result: hi = product[2W-1:W], lo = product[W-1:0].
- Divide result: lo = quotient, hi = remainder. Truncation is toward zero.
- Divide by zero (b==0, signed or unsigned): lo = all ones, hi = a (original operand). Full latency; done pulses.
- Signed overflow (a = most negative, b = all ones): lo = a, hi = 0. No trap.
- Flush during CALC or FIX: next state IDLE, hi/lo unchanged, no done pulse, counter irrelevant.
- Flush in IDLE: request ignored, including MTHI/MTLO.
- hi/lo change only on MTHI/MTLO accept, FIX exit, or reset.
- Requests presented while busy are not accepted; req_valid must hold until accepted.

Test Plan:
- WIDTH=32, reset 3 cycles, then idle: hi=0, lo=0, done=0, req_ready=1. MULT a=-3 (FFFFFFFD), b=5 accepted at cycle 0: busy cycles 1–33; done=1 at cycle 34 with hi=FFFFFFFF, lo=FFFFFFF1.
- DIVU a=100, b=7: lo=0000000E, hi=00000002 at cycle 34. Back-to-back DIV a=-7, b=2 accepted at cycle 34: done at cycle 68 with lo=FFFFFFFD, hi=FFFFFFFF.
- DIV a=12345678, b=0: lo=FFFFFFFF, hi=12345678.
- DIV a=80000000, b=FFFFFFFF: lo=80000000, hi=0.
- MTHI a=CAFEF00D then MTLO a=12345678 on consecutive cycles: hi/lo update the cycle after each accept, no done pulse, busy stays 0.
- Flush and reset interplay:
  - MULTU a=FFFFFFFF, b=2, then flush at cycle 10: busy=0 at cycle 11, hi/lo keep prior values, no done pulse.
  - Repeat with reset at cycle 10: hi=lo=0 at cycle 11.
- WIDTH=8 instance: MULTU FF*FF -> hi=FE, lo=01, done at cycle 10. DIV 80/FF -> lo=80, hi=00.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative HI/LO arithmetic unit beside the execute-stage ALU.
//             MULT/MULTU by shift-add and DIV/DIVU by restoring division,
//             one bit per cycle, followed by a one-cycle sign-fix step.
//             MTHI/MTLO write the architectural HI/LO registers directly.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             req_valid/ready  - request handshake (ready only when idle)
//             req_op           - 000 MULT 001 MULTU 010 DIV 011 DIVU
//                                100 MTHI 101 MTLO 110/111 no-op
//             req_a, req_b     - rs / rt operands
//             flush            - abort in-flight op, block acceptance
//             busy, done       - unit occupied / one-cycle result pulse
//             hi, lo           - architectural HI/LO registers
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    if (WIDTH < 4) begin : g_width_check
        $error("muldiv_unit: WIDTH must be at least 4");
    end

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_FIX  = 2'd2;

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mag_a;     // |a|: multiplicand, or dividend magnitude
    logic [WIDTH-1:0]   r_mag_b;     // |b|: divisor (multiplier lives in r_acc)
    logic [2*WIDTH-1:0] r_acc;       // mult: {partial, multiplier}; div: {rem, quo}
    logic               r_is_div;
    logic               r_neg_res;   // sign(a) ^ sign(b) for product/quotient
    logic               r_neg_a;     // remainder follows the dividend sign
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_accept = req_valid & req_ready & ~flush;
    assign w_signed = ~req_op[0];
    assign w_sign_a = w_signed & req_a[WIDTH-1];
    assign w_sign_b = w_signed & req_b[WIDTH-1];
    assign w_abs_a  = w_sign_a ? -req_a : req_a;
    assign w_abs_b  = w_sign_b ? -req_b : req_b;

    // ------------------------------------------------------------------
    // One shift-add multiply step: add multiplicand into the upper half
    // when the current multiplier LSB is set, then shift right (carry in).
    // ------------------------------------------------------------------
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_a};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One restoring divide step on {rem, quo}: shift in the next dividend
    // bit and trial-subtract. Bit WIDTH of the trial is the borrow.
    // ------------------------------------------------------------------
    assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_mag_b};
    assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                            : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    // ------------------------------------------------------------------
    // Sign correction and special cases applied in FIX.
    // Most-negative / -1 needs no special case: negating the magnitude
    // quotient wraps back to the most-negative value with remainder 0.
    // ------------------------------------------------------------------
    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;

    always_comb begin
        w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_mag_b == '0) begin
                // Divide by zero: LO all ones, HI the original dividend
                w_fix_lo = '1;
                w_fix_hi = r_neg_a ? -r_mag_a : r_mag_a;
            end else begin
                w_fix_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                w_fix_hi = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept && !req_op[2]) begin
                    w_state_next = c_S_CALC;
                end
            end
            c_S_CALC: begin
                if (flush) begin
                    w_state_next = c_S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = c_S_FIX;
                end
            end
            c_S_FIX: begin
                w_state_next = c_S_IDLE;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        if (r_state == c_S_IDLE) begin
            req_ready = ~reset;
            busy      = 1'b0;
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_acc     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_a   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        case (req_op)
                            c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
                                r_mag_a   <= w_abs_a;
                                r_mag_b   <= w_abs_b;
                                r_is_div  <= req_op[1];
                                r_neg_res <= w_sign_a ^ w_sign_b;
                                r_neg_a   <= w_sign_a;
                                r_cnt     <= c_CNT_INIT;
                                // Lower half seeds the multiplier or the dividend
                                r_acc     <= {{WIDTH{1'b0}}, (req_op[1] ? w_abs_a : w_abs_b)};
                            end
                            c_OP_MTHI: r_hi <= req_a;
                            c_OP_MTLO: r_lo <= req_a;
                            default: ;
                        endcase
                    end
                end
                c_S_CALC: begin
                    if (!flush) begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_S_FIX: begin
                    if (!flush) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
